// File: rtl/pe_filter_sequencer_pkg.sv
// Shared parameters, FSM encoding and cfg clamp helpers for the PE filter-load sequencer.
package pe_filter_sequencer_pkg;
  localparam int NB_FILTER     = 4;
  localparam int FILTER_DW     = 72;
  localparam int TIN_MAX       = 4;
  localparam int W_TIN         = $clog2(TIN_MAX);
  localparam int W_CHANNEL     = 10;
  localparam int FILTER_BUF_AW = 16;
  localparam int FB_DELAY      = 1;
  localparam int W_DATA        = NB_FILTER * FILTER_DW;
  localparam int W_ADDR_MATH   = W_CHANNEL + W_TIN + 1;

  typedef logic [W_TIN:0]       tin_cfg_t;
  typedef logic [W_TIN-1:0]     off_t;
  typedef logic [W_CHANNEL-1:0] chan_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_FETCH = 2'd2,
    ST_DONE  = 2'd3
  } fseq_state_t;

  function automatic tin_cfg_t clamp_tin(input tin_cfg_t tin);
    if (tin == '0 || tin > tin_cfg_t'(TIN_MAX)) return tin_cfg_t'(1);
    return tin;
  endfunction

  function automatic chan_t clamp_q(input chan_t q);
    if (q == '0) return chan_t'(1);
    return q;
  endfunction
endpackage

// File: rtl/pe_filter_sequencer_if.sv
// Controller / filter-buffer / PE side signals of the filter sequencer; master = sequencer.
interface pe_filter_sequencer_if;
  import pe_filter_sequencer_pkg::*;

  logic                     c_ctrl_csync_run;
  chan_t                    cfg_q_channel;
  tin_cfg_t                 cfg_tin;
  logic                     fb_req_possible;
  logic                     o_fb_req;
  logic [FILTER_BUF_AW-1:0] o_fb_addr;
  logic [W_DATA-1:0]        fb_data_flat;
  logic                     change_filter;
  logic                     o_load_filter;
  off_t                     o_load_idx;
  logic                     o_load_bank;
  logic [W_DATA-1:0]        o_filter_data;
  logic                     o_active_bank;
  logic                     o_filter_ready;
  logic                     o_stall;
  logic                     o_pe_csync_done;
  logic                     o_err_underflow;

  modport master (
    input  c_ctrl_csync_run, cfg_q_channel, cfg_tin, fb_req_possible, fb_data_flat, change_filter,
    output o_fb_req, o_fb_addr, o_load_filter, o_load_idx, o_load_bank, o_filter_data,
           o_active_bank, o_filter_ready, o_stall, o_pe_csync_done, o_err_underflow
  );

  modport slave (
    output c_ctrl_csync_run, cfg_q_channel, cfg_tin, fb_req_possible, fb_data_flat, change_filter,
    input  o_fb_req, o_fb_addr, o_load_filter, o_load_idx, o_load_bank, o_filter_data,
           o_active_bank, o_filter_ready, o_stall, o_pe_csync_done, o_err_underflow
  );
endinterface

// File: rtl/pe_fseq_delay_pipe.sv
// Fixed-depth shift register with synchronous squash; models the filter buffer read latency.
module pe_fseq_delay_pipe #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_squash,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);
  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else if (i_squash) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_data = r_stage[DEPTH-1];
endmodule

// File: rtl/pe_filter_sequencer.sv
// Filter tile fetch/load sequencer for conv_pe. Define PE_FSEQ_DBUF_EN for two PE weight banks with prefetch.
// state | meaning
// IDLE  | no csync seen since reset
// ARM   | waiting for buffer data and a free target bank
// FETCH | one filter-buffer read per cycle, offset 0..tin-1
// DONE  | reserve target bank, advance tile index
module pe_filter_sequencer #(
  parameter int FB_DELAY = pe_filter_sequencer_pkg::FB_DELAY
) (
  input logic                   clk,
  input logic                   rst,
  pe_filter_sequencer_if.master bus
);
  import pe_filter_sequencer_pkg::*;

  localparam int W_PIPE = W_TIN + 2;

  fseq_state_t             r_state, w_state_nxt;
  logic                    r_csync_d, w_csync_rise;
  tin_cfg_t                r_tin;
  chan_t                   r_qch, r_tile;
  off_t                    r_offset, w_ld_off;
  logic [1:0]              r_valid, r_ready;
  logic                    r_active, r_fill, r_done, r_err;
  logic                    w_fill_free, w_last_off, w_fb_req, w_filter_ready, w_change_ok;
  logic                    w_ld_req, w_ld_bank, w_ld_last;
  logic [W_PIPE-1:0]       w_pipe_out;
  logic [W_ADDR_MATH-1:0]  w_addr_full;

`ifdef PE_FSEQ_DBUF_EN
  localparam bit DBUF = 1'b1;
  assign bus.o_load_bank   = w_ld_req & w_ld_bank;
  assign bus.o_active_bank = r_active;
`else
  localparam bit DBUF = 1'b0;
  assign bus.o_load_bank   = 1'b0;
  assign bus.o_active_bank = 1'b0;
`endif

  assign w_csync_rise   = bus.c_ctrl_csync_run && !r_csync_d;
  assign w_fill_free    = !r_valid[r_fill];
  assign w_last_off     = ({1'b0, r_offset} == r_tin - tin_cfg_t'(1));
  assign w_filter_ready = r_ready[r_active];
  assign w_change_ok    = bus.change_filter && w_filter_ready;
  assign w_addr_full    = W_ADDR_MATH'(r_tile) * W_ADDR_MATH'(r_tin) + W_ADDR_MATH'(r_offset);

  always_comb begin
    w_state_nxt = r_state;
    w_fb_req    = 1'b0;
    case (r_state)
      ST_IDLE:  w_state_nxt = ST_IDLE;
      ST_ARM:   if (bus.fb_req_possible && w_fill_free) w_state_nxt = ST_FETCH;
      ST_FETCH: begin
        w_fb_req = 1'b1;
        if (w_last_off) w_state_nxt = ST_DONE;
      end
      ST_DONE:  w_state_nxt = ST_ARM;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (w_csync_rise) w_state_nxt = ST_ARM;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // A csync edge restarts the pass; in-flight loads are squashed with the same edge.
  pe_fseq_delay_pipe #(.DEPTH(FB_DELAY), .WIDTH(W_PIPE)) u_load_pipe (
    .clk      (clk),
    .rst      (rst),
    .i_squash (w_csync_rise),
    .i_data   ({w_fb_req, r_offset, r_fill}),
    .o_data   (w_pipe_out)
  );

  assign {w_ld_req, w_ld_off, w_ld_bank} = w_pipe_out;
  assign w_ld_last = ({1'b0, w_ld_off} == r_tin - tin_cfg_t'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_csync_d <= 1'b0;
      r_tin     <= tin_cfg_t'(1);
      r_qch     <= chan_t'(1);
      r_tile    <= '0;
      r_offset  <= '0;
      r_valid   <= '0;
      r_ready   <= '0;
      r_active  <= 1'b0;
      r_fill    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_csync_d <= bus.c_ctrl_csync_run;
      r_done    <= bus.c_ctrl_csync_run && w_filter_ready && !w_csync_rise;
      if (bus.change_filter && !w_filter_ready) r_err <= 1'b1;
      if (w_csync_rise) begin
        r_tin    <= clamp_tin(bus.cfg_tin);
        r_qch    <= clamp_q(bus.cfg_q_channel);
        r_tile   <= '0;
        r_offset <= '0;
        r_valid  <= '0;
        r_ready  <= '0;
        r_active <= 1'b0;
        r_fill   <= 1'b0;
      end else begin
        if (r_state == ST_FETCH) r_offset <= w_last_off ? '0 : r_offset + 1'b1;
        if (w_change_ok) begin
          r_valid[r_active] <= 1'b0;
          r_ready[r_active] <= 1'b0;
          if (DBUF) r_active <= ~r_active;
        end
        if (r_state == ST_DONE) begin
          r_valid[r_fill] <= 1'b1;
          r_tile          <= (r_tile == r_qch - chan_t'(1)) ? '0 : r_tile + 1'b1;
          if (DBUF) r_fill <= ~r_fill;
        end
        // Readiness follows the last write into the PE, not the DONE state.
        if (w_ld_req && w_ld_last) r_ready[w_ld_bank] <= 1'b1;
      end
    end
  end

  assign bus.o_fb_req        = w_fb_req;
  assign bus.o_fb_addr       = FILTER_BUF_AW'(w_addr_full);
  assign bus.o_load_filter   = w_ld_req;
  assign bus.o_load_idx      = w_ld_req ? w_ld_off : '0;
  assign bus.o_filter_data   = w_ld_req ? bus.fb_data_flat : '0;
  assign bus.o_filter_ready  = w_filter_ready;
  assign bus.o_stall         = r_csync_d && !w_filter_ready;
  assign bus.o_pe_csync_done = r_done;
  assign bus.o_err_underflow = r_err;
endmodule

// File: tb/tb_pe_filter_sequencer.sv
// Directed bench: instance A uses a 1-cycle filter buffer, instance B a 3-cycle one.
module tb_pe_filter_sequencer;
  import pe_filter_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  pe_filter_sequencer_if bus_a ();
  pe_filter_sequencer_if bus_b ();

  pe_filter_sequencer #(.FB_DELAY(1)) u_dut_a (.clk(clk), .rst(rst_a), .bus(bus_a.master));
  pe_filter_sequencer #(.FB_DELAY(3)) u_dut_b (.clk(clk), .rst(rst_b), .bus(bus_b.master));

  int n_checks = 0;
  int n_fail   = 0;
  logic [W_DATA-1:0] data_a, data_b;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_req_a(input string tag);
    int n = 0;
    while (!bus_a.o_fb_req && n < 20) begin tick(); n++; end
    chk(tag, bus_a.o_fb_req, 1);
  endtask

  task automatic pulse_cf_a();
    bus_a.change_filter = 1'b1;
    tick();
    bus_a.change_filter = 1'b0;
  endtask

  // Entered on the first request cycle of a tin=4 tile.
  task automatic run_tile_a(input int base);
    for (int k = 0; k < 4; k++) begin
      chk("t2_req", bus_a.o_fb_req, 1);
      chk("t2_addr", bus_a.o_fb_addr, base + k);
      if (k > 0) begin
        chk("t2_ld", bus_a.o_load_filter, 1);
        chk("t2_idx", bus_a.o_load_idx, k - 1);
        chk("t2_data", bus_a.o_filter_data[63:0], data_a[63:0]);
      end
      tick();
    end
    chk("t2_req_end", bus_a.o_fb_req, 0);
    chk("t2_ld_last", bus_a.o_load_filter, 1);
    chk("t2_idx_last", bus_a.o_load_idx, 3);
    chk("t2_ready_early", bus_a.o_filter_ready, 0);
    tick();
    chk("t2_ready", bus_a.o_filter_ready, 1);
    chk("t2_stall", bus_a.o_stall, 0);
    chk("t2_ld_off", bus_a.o_load_filter, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    data_a = {4{72'h5A_1234_5678_9ABC_DEF0}};
    data_b = {4{72'hC3_0F0F_1111_2222_3333}};
    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.c_ctrl_csync_run = 0; bus_a.cfg_q_channel = 3; bus_a.cfg_tin = 4;
    bus_a.fb_req_possible = 0; bus_a.change_filter = 0; bus_a.fb_data_flat = data_a;
    bus_b.c_ctrl_csync_run = 0; bus_b.cfg_q_channel = 3; bus_b.cfg_tin = 4;
    bus_b.fb_req_possible = 0; bus_b.change_filter = 0; bus_b.fb_data_flat = data_b;
    repeat (2) tick();

    chk("rst_fb_req", bus_a.o_fb_req, 0);
    chk("rst_addr", bus_a.o_fb_addr, 0);
    chk("rst_ld", bus_a.o_load_filter, 0);
    chk("rst_data", bus_a.o_filter_data[63:0], 0);
    chk("rst_ready", bus_a.o_filter_ready, 0);
    chk("rst_stall", bus_a.o_stall, 0);
    chk("rst_done", bus_a.o_pe_csync_done, 0);
    chk("rst_err", bus_a.o_err_underflow, 0);
    chk("rst_act", bus_a.o_active_bank, 0);

    rst_a = 1'b0; rst_b = 1'b0;
    tick();
    bus_a.c_ctrl_csync_run = 1'b1;
    tick();
    chk("t4_stall", bus_a.o_stall, 1);
    chk("t4_req0", bus_a.o_fb_req, 0);

    pulse_cf_a();
    chk("t5_err", bus_a.o_err_underflow, 1);
    chk("t5_act", bus_a.o_active_bank, 0);
    chk("t5_ready", bus_a.o_filter_ready, 0);

    bad = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (bus_a.o_fb_req || !bus_a.o_stall) bad++;
    end
    chk("t4_hold_bad_cycles", bad, 0);
    bus_a.fb_req_possible = 1'b1;
    tick();
    chk("t4_start_req", bus_a.o_fb_req, 1);
    chk("t4_start_addr", bus_a.o_fb_addr, 0);

`ifndef PE_FSEQ_DBUF_EN
    run_tile_a(0);
    repeat (2) tick();
    chk("t2_wait_cf", bus_a.o_fb_req, 0);
    pulse_cf_a();
    wait_req_a("t2_tile1_start");
    run_tile_a(4);
    pulse_cf_a();
    wait_req_a("t2_tile2_start");
    run_tile_a(8);
    pulse_cf_a();
    wait_req_a("t2_wrap_start");
    run_tile_a(0);
    tick();
    chk("t2_csync_done", bus_a.o_pe_csync_done, 1);
    chk("t5_err_sticky", bus_a.o_err_underflow, 1);
`endif

    n = 0;
    while (!bus_a.o_fb_req && n < 30) begin
      bus_a.change_filter = bus_a.o_filter_ready;
      tick(); n++;
    end
    bus_a.change_filter = 1'b0;
    chk("t1_in_fetch", bus_a.o_fb_req, 1);
    tick();
    rst_a = 1'b1;
    bus_a.c_ctrl_csync_run = 1'b0;
    tick();
    chk("t1_req", bus_a.o_fb_req, 0);
    chk("t1_addr", bus_a.o_fb_addr, 0);
    chk("t1_ld", bus_a.o_load_filter, 0);
    chk("t1_data", bus_a.o_filter_data[63:0], 0);
    chk("t1_err", bus_a.o_err_underflow, 0);
    chk("t1_ready", bus_a.o_filter_ready, 0);
    chk("t1_done", bus_a.o_pe_csync_done, 0);
    rst_a = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus_a.o_load_filter || bus_a.o_fb_req) bad++;
    end
    chk("t1_quiet_cycles", bad, 0);

`ifdef PE_FSEQ_DBUF_EN
    bus_a.cfg_tin = 2;
    bus_a.c_ctrl_csync_run = 1'b1;
    tick();
    wait_req_a("t3_tile0_start");
    chk("t3_tile0_addr", bus_a.o_fb_addr, 0);
    n = 0;
    while (!(bus_a.o_fb_req && bus_a.o_fb_addr == 2) && n < 20) begin tick(); n++; end
    chk("t3_prefetch_req", bus_a.o_fb_req, 1);
    chk("t3_prefetch_act", bus_a.o_active_bank, 0);
    chk("t3_prefetch_ready", bus_a.o_filter_ready, 1);
    bad = 0; n = 0;
    while (!(bus_a.o_load_filter && bus_a.o_load_bank && bus_a.o_load_idx == 1) && n < 20) begin
      if (bus_a.o_stall) bad++;
      tick(); n++;
    end
    chk("t3_last_ld_bank1", bus_a.o_load_bank, 1);
    pulse_cf_a();
    chk("t3_flip_act", bus_a.o_active_bank, 1);
    chk("t3_flip_ready", bus_a.o_filter_ready, 1);
    chk("t3_flip_stall", bus_a.o_stall, 0);
    chk("t3_stall_cycles", bad, 0);
    wait_req_a("t3_tile2_start");
    chk("t3_tile2_addr", bus_a.o_fb_addr, 4);
    chk("t3_tile2_act", bus_a.o_active_bank, 1);
`endif

    bus_b.fb_req_possible = 1'b1;
    bus_b.c_ctrl_csync_run = 1'b1;
    tick();
    n = 0;
    while (!bus_b.o_fb_req && n < 20) begin tick(); n++; end
    chk("t6_first_req", bus_b.o_fb_req, 1);
    chk("t6_first_addr", bus_b.o_fb_addr, 0);
    repeat (2) tick();
    chk("t6_lat_early", bus_b.o_load_filter, 0);
    tick();
    chk("t6_lat_ld", bus_b.o_load_filter, 1);
    chk("t6_lat_idx", bus_b.o_load_idx, 0);
    chk("t6_lat_data", bus_b.o_filter_data[63:0], data_b[63:0]);
    bus_b.c_ctrl_csync_run = 1'b0;
    n = 0;
    while (!(bus_b.o_fb_req && bus_b.o_fb_addr == 9) && n < 80) begin
      bus_b.change_filter = bus_b.o_filter_ready;
      tick(); n++;
    end
    bus_b.change_filter = 1'b0;
    chk("t6_reach_tile2_off1", bus_b.o_fb_addr, 9);
    bus_b.c_ctrl_csync_run = 1'b1;
    tick();
    chk("t6_abort_req", bus_b.o_fb_req, 0);
    chk("t6_abort_ld", bus_b.o_load_filter, 0);
    chk("t6_abort_ready", bus_b.o_filter_ready, 0);
    chk("t6_abort_done", bus_b.o_pe_csync_done, 0);
    tick();
    chk("t6_restart_req", bus_b.o_fb_req, 1);
    chk("t6_restart_addr", bus_b.o_fb_addr, 0);
    chk("t6_stale_ld_a", bus_b.o_load_filter, 0);
    tick();
    chk("t6_stale_ld_b", bus_b.o_load_filter, 0);
    tick();
    chk("t6_stale_ld_c", bus_b.o_load_filter, 0);
    chk("t6_done_low", bus_b.o_pe_csync_done, 0);
    tick();
    chk("t6_new_ld", bus_b.o_load_filter, 1);
    chk("t6_new_idx", bus_b.o_load_idx, 0);
    n = 0;
    while (!bus_b.o_filter_ready && n < 20) begin
      if (bus_b.o_pe_csync_done) bad++;
      tick(); n++;
    end
    chk("t6_reload_ready", bus_b.o_filter_ready, 1);
    chk("t6_done_before", bus_b.o_pe_csync_done, 0);
    tick();
    chk("t6_done_after", bus_b.o_pe_csync_done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
